// File: rtl/regfile.sv
// Integer register file: NUM_REGS x XLEN storage, one write-back port and two
// combinational read ports with write-through bypass; x0 always reads as zero.
module regfile #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [4:0]      wb_rd,
    input  logic            wb_rd_op,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic            id_rs1_op,
    input  logic [4:0]      id_rs1,
    output logic [XLEN-1:0] id_rs1_data,
    input  logic            id_rs2_op,
    input  logic [4:0]      id_rs2,
    output logic [XLEN-1:0] id_rs2_data
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];
    logic [XLEN-1:0] rs1_stored_s;
    logic [XLEN-1:0] rs2_stored_s;

    // Read-port priority: reset, disabled port, x0, same-cycle bypass, storage.
    function automatic logic [XLEN-1:0] read_sel(
        input logic            rst,
        input logic            op,
        input logic [4:0]      idx,
        input logic            w_op,
        input logic [4:0]      w_idx,
        input logic [XLEN-1:0] w_data,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] r;
        if (rst) begin
            r = {XLEN{1'b0}};
        end else if (!op) begin
            r = {XLEN{1'b0}};
        end else if (idx == 5'd0) begin
            r = {XLEN{1'b0}};
        end else if (w_op && (w_idx == idx)) begin
            r = w_data;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Next-state of storage: clear on reset, single-entry write otherwise.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RST) begin
                regs_d[i] = {XLEN{1'b0}};
            end else if (wb_rd_op && (wb_rd != 5'd0) && (int'(wb_rd) == i)) begin
                regs_d[i] = wb_rd_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage register update.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Stored-value lookup; indices beyond the implemented range read as zero.
    always_comb begin
        rs1_stored_s = {XLEN{1'b0}};
        rs2_stored_s = {XLEN{1'b0}};
        if (int'(id_rs1) < NUM_REGS) begin
            rs1_stored_s = regs_q[id_rs1];
        end else begin
            rs1_stored_s = {XLEN{1'b0}};
        end
        if (int'(id_rs2) < NUM_REGS) begin
            rs2_stored_s = regs_q[id_rs2];
        end else begin
            rs2_stored_s = {XLEN{1'b0}};
        end
    end

    // Read ports are purely combinational.
    always_comb begin
        id_rs1_data = read_sel(RST, id_rs1_op, id_rs1, wb_rd_op, wb_rd, wb_rd_data, rs1_stored_s);
        id_rs2_data = read_sel(RST, id_rs2_op, id_rs2, wb_rd_op, wb_rd, wb_rd_data, rs2_stored_s);
    end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: directed scenarios followed by random traffic,
// checked against an array-based reference model.
module tb_regfile;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  wb_rd;
    logic        wb_rd_op;
    logic [31:0] wb_rd_data;
    logic        id_rs1_op;
    logic [4:0]  id_rs1;
    logic [31:0] id_rs1_data;
    logic        id_rs2_op;
    logic [4:0]  id_rs2;
    logic [31:0] id_rs2_data;

    regfile #(.NUM_REGS(32), .XLEN(32)) dut (
        .CLK(CLK), .RST(RST),
        .wb_rd(wb_rd), .wb_rd_op(wb_rd_op), .wb_rd_data(wb_rd_data),
        .id_rs1_op(id_rs1_op), .id_rs1(id_rs1), .id_rs1_data(id_rs1_data),
        .id_rs2_op(id_rs2_op), .id_rs2(id_rs2), .id_rs2_data(id_rs2_data)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;

    // Architectural read as seen by a decode stage in the current cycle.
    function automatic logic [31:0] ref_read(input logic rst, input logic op, input logic [4:0] idx,
                                             input logic wop, input logic [4:0] wrd,
                                             input logic [31:0] wdata);
        if (rst || !op || idx == 5'd0) return 32'd0;
        if (wop && wrd == idx) return wdata;
        return model[idx];
    endfunction

    // Drive one cycle (inputs set #1 after a rising edge), queue expectation,
    // then advance the model across the next rising edge.
    task automatic cycle(input string name, input logic rst, input logic wop, input logic [4:0] wrd,
                         input logic [31:0] wdata, input logic op1, input logic [4:0] rs1,
                         input logic op2, input logic [4:0] rs2);
        exp_t e;
        RST = rst; wb_rd_op = wop; wb_rd = wrd; wb_rd_data = wdata;
        id_rs1_op = op1; id_rs1 = rs1; id_rs2_op = op2; id_rs2 = rs2;
        e.name = name;
        e.e1 = ref_read(rst, op1, rs1, wop, wrd, wdata);
        e.e2 = ref_read(rst, op2, rs2, wop, wrd, wdata);
        sb_q.push_back(e);
        @(posedge CLK);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (wop && wrd != 5'd0) begin
            model[wrd] = wdata;
        end
        #1;
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (id_rs1_data !== e.e1) begin
                errors++;
                $display("FAIL %s rs1: got %h expected %h", e.name, id_rs1_data, e.e1);
            end
            checks++;
            if (id_rs2_data !== e.e2) begin
                errors++;
                $display("FAIL %s rs2: got %h expected %h", e.name, id_rs2_data, e.e2);
            end
        end
    end

    initial begin
        logic [4:0]  wrd, r1, r2;
        logic        rst, wop;
        logic [31:0] wd;
        int          budget;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        RST = 1'b1; wb_rd_op = 1'b0; wb_rd = 5'd0; wb_rd_data = 32'd0;
        id_rs1_op = 1'b0; id_rs1 = 5'd0; id_rs2_op = 1'b0; id_rs2 = 5'd0;
        @(posedge CLK); #1;

        // Reset with a write pending and reads active: outputs must be zero.
        cycle("reset_rd", 1'b1, 1'b1, 5'd4, 32'hCAFE0001, 1'b1, 5'd4, 1'b1, 5'd4);
        cycle("reset_rd2", 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b1, 5'd31);
        for (int i = 1; i < 32; i++)
            cycle("post_reset_zero", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(32 - i));

        cycle("wr_x5", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 1'b0, 5'd5);
        cycle("rd_x5_x6", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd6);
        cycle("bypass_x7", 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7);
        cycle("stored_x7", 1'b0, 1'b0, 5'd7, 32'h0BADF00D, 1'b1, 5'd7, 1'b1, 5'd5);
        cycle("wr_x0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        cycle("rd_x0", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        cycle("wr_x3", 1'b0, 1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle("no_op_wr_x3", 1'b0, 1'b0, 5'd3, 32'h000000AA, 1'b1, 5'd3, 1'b0, 5'd3);
        cycle("rd_x3", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3);
        cycle("rst_wr_x9", 1'b1, 1'b1, 5'd9, 32'h00000055, 1'b1, 5'd9, 1'b1, 5'd9);
        cycle("rd_x9", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd5);

        // Random traffic, biased toward bypass hits and a sparse reset.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            wop = $urandom_range(0, 2) != 0;
            wrd = 5'($urandom_range(0, 31));
            wd  = $urandom;
            r1  = ($urandom_range(0, 3) == 0) ? wrd : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? wrd : 5'($urandom_range(0, 31));
            cycle("random", rst, wop, wrd, wd, $urandom_range(0, 7) != 0, r1,
                  $urandom_range(0, 7) != 0, r2);
        end

        budget = 10;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
